// File: rtl/hazard_ctrl.sv
// Stall/bubble and forwarding-select controller for a 5-stage MIPS pipeline, with a mult/div busy window.
// Optional feature: define HAZARD_MD_EN to enable the mult/div busy counter and HI/LO stall term.
module hazard_ctrl #(
    parameter int MD_MUL_CYC = 5,
    parameter int MD_DIV_CYC = 10,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [1:0]       id_tuse_rs,
    input  logic [1:0]       id_tuse_rt,
    input  logic [4:0]       id_dst,
    input  logic [1:0]       id_tnew,
    input  logic             id_uses_md,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_clr,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // W only ever holds finished results, so its tnew is not stored.
    logic [4:0]       r_e_dst, r_m_dst, r_w_dst;
    logic [1:0]       r_e_tnew, r_m_tnew;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_src  [2];
    logic [1:0] w_tuse [2];
    logic [1:0] w_fwd  [2];
    logic [1:0] w_data_stall;
    logic       w_md_stall;
    logic       w_stall;

    assign w_src[0]  = id_rs;
    assign w_src[1]  = id_rt;
    assign w_tuse[0] = id_tuse_rs;
    assign w_tuse[1] = id_tuse_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_src
            logic w_live, w_hit_e, w_hit_m, w_hit_w;
            assign w_live  = (w_src[gi] != 5'd0) && (w_tuse[gi] != 2'd3);
            assign w_hit_e = w_live && (r_e_dst == w_src[gi]);
            assign w_hit_m = w_live && (r_m_dst == w_src[gi]);
            assign w_hit_w = w_live && (r_w_dst == w_src[gi]);
            assign w_data_stall[gi] = (w_hit_e && (r_e_tnew > w_tuse[gi])) ||
                                      (w_hit_m && (r_m_tnew > w_tuse[gi]));
            assign w_fwd[gi] = w_hit_e ? 2'd1 :
                               w_hit_m ? 2'd2 :
                               w_hit_w ? 2'd3 : 2'd0;
        end
    endgenerate

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (MD_DIV_CYC > MD_MUL_CYC) ? MD_DIV_CYC : MD_MUL_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [MD_W-1:0] r_md_cnt;

    // A new start always reloads, even if a previous operation is still counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start) begin
            r_md_cnt <= md_is_div ? MD_W'(MD_DIV_CYC) : MD_W'(MD_MUL_CYC);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = id_uses_md && (md_busy || md_start);
`else
    logic w_unused_md;
    assign w_unused_md = &{1'b0, id_uses_md, md_start, md_is_div};
    assign md_busy     = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    assign w_stall   = ~reset && ((|w_data_stall) || w_md_stall);
    assign stall     = w_stall;
    assign pc_en     = ~w_stall;
    assign if_id_en  = ~w_stall;
    assign id_ex_clr = w_stall;
    assign fwd_rs    = reset ? 2'd0 : w_fwd[0];
    assign fwd_rt    = reset ? 2'd0 : w_fwd[1];
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_dst     <= '0;
            r_e_tnew    <= '0;
            r_m_dst     <= '0;
            r_m_tnew    <= '0;
            r_w_dst     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_w_dst  <= r_m_dst;
            r_m_dst  <= r_e_dst;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            r_e_dst  <= w_stall ? 5'd0 : id_dst;
            r_e_tnew <= w_stall ? 2'd0 : id_tnew;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
